// File: rtl/keypad_tx_pkg.sv
// Shared keypad definitions: FSM states, the special key codes that the vault
// side also decodes, and the row/column to code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    SEND         = 2'd2,
    WAIT_RELEASE = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_CANCEL = 4'hF;
  localparam logic [3:0] KEY_ENTER  = 4'hE;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_CANCEL;
      4'hD: code = 4'h0;
      4'hE: code = KEY_ENTER;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_tx_if.sv
// Keypad-to-vault event link. One-way strobe with no ready: each key_validout
// pulse is one event, and key_code is meaningful only while key_validout is high.
interface keypad_tx_if;
  logic       key_validout;
  logic [3:0] key_code;

  modport master (output key_validout, output key_code);
  modport slave  (input  key_validout, input  key_code);
endinterface

// File: rtl/keypad_tx_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value lets
// active-low inputs come out of reset in their idle state.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_tx.sv
// 4x4 keypad scanner/debouncer that sends one coded event per physical press
// over the keypad_tx_if link; fsm_state exposes the controller state.
module keypad_tx
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int VALID_CYCLES    = 16
) (
  input  logic          MAX10_CLK1_50,
  input  logic          reset,
  input  logic [3:0]    kp_row,
  output logic [3:0]    kp_col,
  keypad_tx_if.master   link,
  output kp_state_t     fsm_state
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int VW = $clog2(VALID_CYCLES + 1);

  kp_state_t      state, state_nxt;
  logic [3:0]     row_s;
  logic [1:0]     col_idx, col_nxt, lat_row, low_row;
  logic [SW-1:0]  scan_cnt;
  logic [DW-1:0]  deb_cnt;
  logic [VW-1:0]  val_cnt;
  logic           key_valid_q;
  logic [3:0]     key_code_q;
  logic           any_low, lat_row_high, scan_wrap, deb_done, val_done;

  sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk (MAX10_CLK1_50),
    .rst (reset),
    .d   (kp_row),
    .q   (row_s)
  );

  assign any_low      = ~&row_s;
  assign lat_row_high = row_s[lat_row];
  assign scan_wrap    = (scan_cnt == SW'(SCAN_DIV - 1));
  assign deb_done     = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign val_done     = (val_cnt == VW'(VALID_CYCLES));
  assign col_nxt      = col_idx + 2'd1;

  // Lowest-index low row wins when several rows are active in one column.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:         if (any_low) state_nxt = DEBOUNCE;
      DEBOUNCE:     if (lat_row_high) state_nxt = SCAN;
                    else if (deb_done) state_nxt = SEND;
      SEND:         if (val_done) state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: if (!any_low && deb_done) state_nxt = SCAN;
      default:      state_nxt = SCAN;
    endcase
  end

  // col_idx doubles as the latched column: it stays frozen outside SCAN, so a
  // failed debounce resumes scanning from the column that was pressed.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      kp_col      <= 4'b1110;
      lat_row     <= 2'd0;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      val_cnt     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      state <= state_nxt;
      case (state)
        SCAN: begin
          if (any_low) begin
            lat_row <= low_row;
            deb_cnt <= '0;
          end else if (scan_wrap) begin
            scan_cnt <= '0;
            col_idx  <= col_nxt;
            kp_col   <= ~(4'b0001 << col_nxt);
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (lat_row_high) begin
            scan_cnt <= '0;
          end else if (deb_done) begin
            key_code_q <= key_lookup(lat_row, col_idx);
            deb_cnt    <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        SEND: begin
          // Code was loaded on entry; the strobe starts one cycle later.
          if (val_done) begin
            key_valid_q <= 1'b0;
            val_cnt     <= '0;
          end else begin
            key_valid_q <= 1'b1;
            val_cnt     <= val_cnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (any_low) begin
            deb_cnt <= '0;
          end else if (deb_done) begin
            deb_cnt  <= '0;
            scan_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign link.key_validout = key_valid_q;
  assign link.key_code     = key_code_q;
  assign fsm_state         = state;

endmodule

// File: tb/tb_keypad_tx.sv
// Bench for keypad_tx: keypad matrix model, expected-code queue filled when a
// press is applied and drained by the strobe monitor.
module tb_keypad_tx;
  import keypad_pkg::*;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int VALID_CYCLES    = 3;

  logic       MAX10_CLK1_50 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] kp_row;
  logic [3:0] kp_col;
  kp_state_t  fsm_state;
  logic [15:0] pressed = '0;

  keypad_tx_if link();

  keypad_tx #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .VALID_CYCLES    (VALID_CYCLES)
  ) dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .reset         (reset),
    .kp_row        (kp_row),
    .kp_col        (kp_col),
    .link          (link),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  int cyc = 0;
  always @(posedge MAX10_CLK1_50) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int         ev_cnt   = 0;
  int         rise_cyc = 0;
  int         width    = 0;
  logic       in_pulse = 1'b0;
  logic [3:0] code_prev = 4'h0;
  logic [3:0] pulse_code = 4'h0;
  logic [3:0] exp_code;

  always @(negedge MAX10_CLK1_50) begin
    if (reset) begin
      in_pulse = 1'b0;
    end else if (link.key_validout && !in_pulse) begin
      in_pulse   = 1'b1;
      width      = 1;
      rise_cyc   = cyc;
      pulse_code = link.key_code;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {28'h0, link.key_code}, 32'hFFFF_FFFF);
      end else begin
        exp_code = exp_q.pop_front();
        check_eq("code_at_rise", link.key_code, exp_code);
        check_eq("code_setup", code_prev, exp_code);
      end
    end else if (link.key_validout) begin
      width++;
      check_eq("code_stable", link.key_code, pulse_code);
    end else if (in_pulse) begin
      check_eq("valid_width", width, VALID_CYCLES);
      check_eq("code_after_pulse", link.key_code, pulse_code);
      in_pulse = 1'b0;
      ev_cnt++;
    end
    code_prev = link.key_code;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge MAX10_CLK1_50);
  endtask

  task automatic reset_dut();
    @(negedge MAX10_CLK1_50);
    reset = 1'b1;
    tick(3);
    check_eq("rst_kp_col", kp_col, 4'b1110);
    check_eq("rst_valid", link.key_validout, 1'b0);
    check_eq("rst_code", link.key_code, 4'h0);
    check_eq("rst_state", fsm_state, SCAN);
    reset = 1'b0;
  endtask

  task automatic wait_events(input int target, input int budget, input string tag);
    int n = 0;
    while (ev_cnt < target && n < budget) begin
      @(negedge MAX10_CLK1_50);
      n++;
    end
    check_eq(tag, ev_cnt, target);
  endtask

  task automatic wait_state(input kp_state_t st, input int budget, input string tag);
    int n = 0;
    while (fsm_state != st && n < budget) begin
      @(negedge MAX10_CLK1_50);
      n++;
    end
    check_eq(tag, fsm_state, st);
  endtask

  // ---------------- tests ----------------
  initial begin
    int base;
    int start;
    logic [3:0] exp_col;

    // Idle scan: each column low for SCAN_DIV cycles, no events.
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check_eq("idle_kp_col", kp_col, exp_col);
      check_eq("idle_valid", link.key_validout, 1'b0);
      tick(1);
    end
    check_eq("idle_code", link.key_code, 4'h0);

    // Clean press of "5" held for 40 cycles: one event, no repeat.
    reset_dut();
    base  = ev_cnt;
    start = cyc;
    exp_q.push_back(4'h5);
    pressed = 16'h0001 << 5;
    wait_events(base + 1, 100, "ev_5");
    while (cyc - start < 40) tick(1);
    check_eq("no_repeat_5", ev_cnt, base + 1);
    check_eq("held_state", fsm_state, WAIT_RELEASE);
    pressed = '0;
    wait_state(SCAN, 60, "release_5");

    // Bouncing "#": only one event, after the contact settles.
    reset_dut();
    base = ev_cnt;
    exp_q.push_back(KEY_ENTER);
    for (int i = 0; i < 30; i++) begin
      pressed[14] = ((i / 3) % 2 == 0);
      tick(1);
    end
    check_eq("bounce_quiet", ev_cnt, base);
    pressed[14] = 1'b1;
    start = cyc;
    wait_events(base + 1, 100, "ev_hash");
    check_eq("bounce_latency", (rise_cyc - start) >= DEBOUNCE_CYCLES, 1'b1);
    pressed = '0;
    wait_state(SCAN, 60, "release_hash");

    // "1" and "9" together: only "1" counts; "9" left briefly produces nothing.
    reset_dut();
    base = ev_cnt;
    exp_q.push_back(4'h1);
    pressed = (16'h0001 << 0) | (16'h0001 << 10);
    wait_events(base + 1, 100, "ev_1");
    check_eq("two_key_wait", fsm_state, WAIT_RELEASE);
    pressed[0] = 1'b0;
    tick(12);
    check_eq("no_ev_9", ev_cnt, base + 1);
    pressed = '0;
    tick(40);
    check_eq("two_key_scan", fsm_state, SCAN);
    check_eq("two_key_count", ev_cnt, base + 1);

    // "*" then "0" with full releases.
    reset_dut();
    base = ev_cnt;
    exp_q.push_back(KEY_CANCEL);
    pressed = 16'h0001 << 12;
    wait_events(base + 1, 100, "ev_star");
    check_eq("code_star", link.key_code, KEY_CANCEL);
    pressed = '0;
    wait_state(SCAN, 60, "release_star");
    exp_q.push_back(4'h0);
    pressed = 16'h0001 << 13;
    wait_events(base + 2, 100, "ev_zero");
    check_eq("code_zero", link.key_code, 4'h0);
    pressed = '0;
    wait_state(SCAN, 60, "release_zero");

    // Reset on the 2nd valid cycle truncates the strobe; held key resends later.
    reset_dut();
    base = ev_cnt;
    exp_q.push_back(4'h5);
    pressed = 16'h0001 << 5;
    start = 0;
    while (!link.key_validout && start < 100) begin
      tick(1);
      start++;
    end
    check_eq("rise_seen", link.key_validout, 1'b1);
    @(negedge MAX10_CLK1_50);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_valid", link.key_validout, 1'b0);
    check_eq("abort_code", link.key_code, 4'h0);
    check_eq("abort_kp_col", kp_col, 4'b1110);
    check_eq("abort_state", fsm_state, SCAN);
    tick(2);
    reset = 1'b0;
    check_eq("abort_no_event", ev_cnt, base);
    exp_q.push_back(4'h5);
    start = cyc;
    wait_events(base + 1, 100, "ev_5_again");
    check_eq("redebounce_latency", (rise_cyc - start) >= DEBOUNCE_CYCLES, 1'b1);
    pressed = '0;
    wait_state(SCAN, 60, "release_5_again");

    check_eq("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_tx.md
# keypad_tx

Keypad-side transmitter for the vault link. Scans a 4x4 matrix keypad and debounces each press. Encodes the pressed key to a 4-bit code and drives a valid strobe plus that code onto the inter-board header, where the vault board's 2-flop synchronizers consume it. One event is sent per physical press; a held key does not repeat.

## Interface
- SCAN_DIV, 50_000: clock cycles each column is driven during scanning (1 ms at 50 MHz).
- DEBOUNCE_CYCLES, 1_000_000: cycles a press or release must be continuously stable (20 ms).
- VALID_CYCLES, 16: width of the key_validout pulse in cycles. Must be ≥ 4 so the receiver's synchronizers see it.
- MAX10_CLK1_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- kp_row  in  4  keypad rows, active-low, externally pulled up, asynchronous to the clock.
- kp_col  out  4  keypad column drive, active-low, one-hot-low.
- key_validout  out  1  event strobe; drives ARDUINO_IO[12] at top level.
- key_code  out  4  key code; drives ARDUINO_IO[11:8] at top level.

## Operation
- kp_row passes through a 2-flop synchronizer before any use.
- The FSM has four states:
  - SCAN: rotate the low column 0→1→2→3→0, advancing every SCAN_DIV cycles. If any synchronized row is low, latch the column index and the lowest-index low row, freeze the column, clear the counter, and go to DEBOUNCE.
  - DEBOUNCE: count cycles while the latched row stays low. If the row goes high, return to SCAN; the column resumes from the latched column and the scan divider restarts. When the count reaches DEBOUNCE_CYCLES-1, load key_code from the latched row/col and go to SEND.
  - SEND: assert key_validout for exactly VALID_CYCLES cycles, then go to WAIT_RELEASE.
  - WAIT_RELEASE: keep the column frozen. All rows must be high for DEBOUNCE_CYCLES consecutive cycles; any low row restarts the count. Then go to SCAN.
- Key map, by row (row 0..3), columns 0..3:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: *, 0, #, D.
- Codes: digits map to their value, A–D map to 0xA–0xD, * = 0xF (cancel), # = 0xE (enter).
- key_code holds its last value until the next debounced press. Receivers must qualify key_code with key_validout, because digit 0 encodes as 0x0.
- Multiple keys pressed: only the first column found in scan order counts; within it, the lowest row wins. Other keys are ignored until full release.
- Pressing a second key during WAIT_RELEASE keeps the FSM waiting and sends no event.

## Timing
- Reset values: state SCAN, kp_col = 4'b1110, key_validout = 0, key_code = 4'h0, all counters 0.
- Reset asserted mid-operation aborts immediately: any strobe in flight is truncated, and the block returns to its reset values.
- Row to FSM: 2 cycles of synchronizer latency.
- key_code changes on the cycle SEND is entered. key_validout rises one cycle later, so code has ≥ 1 cycle of setup before valid.
- key_code is stable for the whole valid pulse and afterward.
- key_validout falls exactly VALID_CYCLES cycles after it rises.
- Minimum spacing between events is VALID_CYCLES + DEBOUNCE_CYCLES (release) + DEBOUNCE_CYCLES (next press).
- Counters are sized with $clog2 of their maximum parameter. The scan divider wraps to 0 at SCAN_DIV-1.

## Structure
- Package keypad_pkg contains:
  - the state enum (SCAN, DEBOUNCE, SEND, WAIT_RELEASE);
  - KEY_CANCEL = 4'hF and KEY_ENTER = 4'hE, shared with the vault-side block;
  - the function key_lookup(row, col) returning the 4-bit code.
- Sub-module sync2: generic 2-flop synchronizer, parameterized width, used for kp_row.
- Everything else lives in keypad_tx: one sequential process for the FSM and counters, and one combinational process for next state.

## Test plan
Benches use SCAN_DIV=4, DEBOUNCE_CYCLES=8, VALID_CYCLES=3; the keypad model pulls row r low whenever the pressed key's column is driven low.
- Reset and idle: assert reset, release, no keys → kp_col cycles 1110→1101→1011→0111 every 4 cycles; key_validout stays 0; key_code stays 0.
- Clean press of "5" (row 1, col 1), held 40 cycles → exactly one pulse:
  - key_code = 0x5 one cycle before key_validout rises;
  - key_validout high exactly 3 cycles;
  - no repeat while the key is held.
- Bounce: "#" toggles low/high every 3 cycles for 30 cycles, then stays low → a single event with code 0xE, only after 8 stable cycles.
- Two keys at once: "1" and "9" pressed together → only 0x1 is sent. Release "1" while "9" is still held → no event. Release all → back to SCAN.
- Sequence "*", "0" with full releases → code 0xF then 0x0, each with its own valid pulse; key_code reads 0x0 after the second pulse.
- Reset during SEND: assert reset on the 2nd valid cycle → key_validout drops that cycle, key_code = 0, kp_col = 1110; the key still held produces a fresh event only after a new debounce.
